// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//  master (controller): consumes op, funct, zero, mem_ready; drives memory
//    handshake (mem_req, memwrite), register enables (irwrite, pcen,
//    regwrite), datapath muxes (iord, memtoreg, regdst, alusrca, alusrcb,
//    pcsrc), ALU/immediate controls (alucont, signext, shiftl16) and err.
//  slave (datapath side): the mirror image.
interface mips_multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       memwrite;
  logic       irwrite;
  logic       pcen;
  logic       regwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucont;
  logic       signext;
  logic       shiftl16;
  logic       err;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, irwrite, pcen, regwrite, iord, memtoreg,
           regdst, alusrca, alusrcb, pcsrc, alucont, signext, shiftl16, err
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, irwrite, pcen, regwrite, iord, memtoreg,
           regdst, alusrca, alusrcb, pcsrc, alucont, signext, shiftl16, err
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM with a stall-tolerant
// memory handshake and a memory-wait watchdog.
//  clk    : clock, rising edge
//  reset  : asynchronous, active-high; returns to FETCH
//  bus    : mips_multicycle_ctrl_if.master (decode inputs, control outputs)
//  TO_W   : watchdog width; a wait is abandoned once 2**TO_W-1 stalled
//           cycles have accumulated and memory is still not ready.
// Outputs are decoded from state (Moore) except pcen (branch & zero) and the
// FETCH-cycle irwrite/pcen, which wait for mem_ready.
module mips_multicycle_ctrl #(
  parameter int unsigned TO_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [TO_W-1:0] WD_MAX = {TO_W{1'b1}};

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEX, S_RTWB, S_BEQEX, S_IMMEX, S_IMMWB, S_JEX
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] wd;
  logic            wait_st;
  logic            timeout;
  logic            op_ok;
  logic            funct_ok;
  logic [2:0]      funct_alu;
  logic            pcwrite;
  logic            branch;

  // Opcode legality and R-type function decode.
  always_comb begin
    op_ok = 1'b0;
    case (bus.op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_LUI, OP_J: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (bus.funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Memory waits; a ready response in the final watchdog cycle still wins.
  assign wait_st = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout = wait_st && !bus.mem_ready && (wd == WD_MAX);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Watchdog: counts consecutive stalled wait cycles, clears otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    wd <= '0;
    else if (wait_st && !bus.mem_ready && !timeout) wd <= wd + TO_W'(1);
    else                                          wd <= '0;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:            state_next = S_MEMADR;
          OP_R:                    state_next = S_RTEX;
          OP_BEQ:                  state_next = S_BEQEX;
          OP_ADDI, OP_ORI, OP_LUI: state_next = S_IMMEX;
          OP_J:                    state_next = S_JEX;
          default:                 state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (bus.mem_ready)  state_next = S_MEMWB;
        else if (timeout)   state_next = S_FETCH;
      end
      S_MEMWR:  if (bus.mem_ready || timeout) state_next = S_FETCH;
      S_RTEX:   state_next = funct_ok ? S_RTWB : S_FETCH;
      S_IMMEX:  state_next = S_IMMWB;
      S_MEMWB, S_RTWB, S_BEQEX, S_IMMWB, S_JEX: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Output decode; everything is held at defaults while reset is asserted.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.alucont  = ALU_ADD;
    bus.signext  = 1'b1;
    bus.shiftl16 = 1'b0;
    bus.err      = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    if (!reset) begin
      bus.err = timeout;
      case (state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.alusrcb = 2'b01;
          bus.irwrite = bus.mem_ready;
          pcwrite     = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alusrcb = 2'b11;
          bus.err     = !op_ok;
        end
        S_MEMADR: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        S_MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.memwrite = 1'b1;
          bus.iord     = 1'b1;
        end
        S_RTEX: begin
          bus.alusrca = 1'b1;
          bus.alucont = funct_alu;
          bus.err     = !funct_ok;
        end
        S_RTWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        S_BEQEX: begin
          bus.alusrca = 1'b1;
          bus.alucont = ALU_SUB;
          bus.pcsrc   = 2'b01;
          branch      = 1'b1;
        end
        S_IMMEX, S_IMMWB: begin
          bus.alusrca  = 1'b1;
          bus.alusrcb  = 2'b10;
          bus.regwrite = (state == S_IMMWB);
          if (bus.op != OP_ADDI) begin
            bus.alucont  = ALU_OR;
            bus.signext  = 1'b0;
            bus.shiftl16 = (bus.op == OP_LUI);
          end
        end
        S_JEX: begin
          bus.pcsrc = 2'b10;
          pcwrite   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pcen = pcwrite | (branch & bus.zero);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: self-checking bench for mips_multicycle_ctrl.
// Each instruction is expanded by a reference model into a cycle plan of
// {mem_ready, zero, expected outputs}; the plan is applied and every cycle
// compared. Directed table entries also check per-instruction totals.
module tb_mips_multicycle_ctrl;
  localparam int unsigned TO_W = 3;
  localparam int WD_LIMIT = 7;  // stalled cycles tolerated with TO_W=3

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, ORI = 6'b001101,
                         LUI = 6'b001111, JMP = 6'b000010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus();
  mips_multicycle_ctrl #(.TO_W(TO_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic mem_req, memwrite, irwrite, pcen, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucont;
    logic signext, shiftl16, err;
  } ctl_t;

  typedef struct {
    logic rdy;
    logic z;
    ctl_t e;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         fs, ms;
    int         n_req, n_rw, n_pcen, n_err;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  cyc_t plan[$];
  bit   rnd_mode;
  logic zfix;
  int   n_req, n_rw, n_pcen, n_err;

  function automatic ctl_t dflt();
    ctl_t c = '0;
    c.alucont = 3'b010;
    c.signext = 1'b1;
    return c;
  endfunction

  function automatic ctl_t act();
    ctl_t c;
    c.mem_req = bus.mem_req;   c.memwrite = bus.memwrite; c.irwrite = bus.irwrite;
    c.pcen = bus.pcen;         c.regwrite = bus.regwrite; c.iord = bus.iord;
    c.memtoreg = bus.memtoreg; c.regdst = bus.regdst;     c.alusrca = bus.alusrca;
    c.alusrcb = bus.alusrcb;   c.pcsrc = bus.pcsrc;       c.alucont = bus.alucont;
    c.signext = bus.signext;   c.shiftl16 = bus.shiftl16; c.err = bus.err;
    return c;
  endfunction

  function automatic logic pick_z();
    return rnd_mode ? 1'($urandom_range(0, 1)) : zfix;
  endfunction

  function automatic logic pick_rdy();
    return rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic push(input ctl_t e, input logic rdy, input logic z);
    cyc_t c;
    c.rdy = rdy; c.z = z; c.e = e;
    plan.push_back(c);
  endtask

  // One memory access: stalls, then either completion or a watchdog abort.
  task automatic add_access(input ctl_t e, input int stalls, input bit fetch, output bit ok);
    ctl_t t;
    for (int i = 0; i < stalls && i < WD_LIMIT; i++) push(e, 1'b0, pick_z());
    t = e;
    if (stalls > WD_LIMIT) begin
      t.err = 1'b1;
      push(t, 1'b0, pick_z());
      ok = 1'b0;
    end else begin
      if (fetch) begin t.irwrite = 1'b1; t.pcen = 1'b1; end
      push(t, 1'b1, pick_z());
      ok = 1'b1;
    end
  endtask

  // Reference model: expected cycle sequence of one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] funct, input int fs, input int ms);
    ctl_t e;
    bit ok;
    bit legal;
    logic z;
    logic [2:0] alu;
    plan.delete();
    e = dflt(); e.mem_req = 1'b1; e.alusrcb = 2'b01;
    add_access(e, fs, 1'b1, ok);
    if (!ok) return;
    e = dflt(); e.alusrcb = 2'b11;
    legal = op inside {LW, SW, RT, BEQ, ADDI, ORI, LUI, JMP};
    e.err = !legal;
    push(e, pick_rdy(), pick_z());
    if (!legal) return;
    case (op)
      LW, SW: begin
        e = dflt(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        push(e, pick_rdy(), pick_z());
        e = dflt(); e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = (op == SW);
        add_access(e, ms, 1'b0, ok);
        if (ok && op == LW) begin
          e = dflt(); e.regwrite = 1'b1; e.memtoreg = 1'b1;
          push(e, pick_rdy(), pick_z());
        end
      end
      RT: begin
        legal = 1'b1; alu = 3'b010;
        case (funct)
          6'b100000: alu = 3'b010;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b000;
          6'b100101: alu = 3'b001;
          6'b101010: alu = 3'b111;
          default:   legal = 1'b0;
        endcase
        e = dflt(); e.alusrca = 1'b1; e.alucont = alu; e.err = !legal;
        push(e, pick_rdy(), pick_z());
        if (legal) begin
          e = dflt(); e.regwrite = 1'b1; e.regdst = 1'b1;
          push(e, pick_rdy(), pick_z());
        end
      end
      BEQ: begin
        z = pick_z();
        e = dflt(); e.alusrca = 1'b1; e.alucont = 3'b110; e.pcsrc = 2'b01; e.pcen = z;
        push(e, pick_rdy(), z);
      end
      ADDI, ORI, LUI: begin
        e = dflt(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
        if (op != ADDI) begin e.alucont = 3'b001; e.signext = 1'b0; end
        e.shiftl16 = (op == LUI);
        push(e, pick_rdy(), pick_z());
        e.regwrite = 1'b1;
        push(e, pick_rdy(), pick_z());
      end
      default: begin
        e = dflt(); e.pcsrc = 2'b10; e.pcen = 1'b1;
        push(e, pick_rdy(), pick_z());
      end
    endcase
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Apply plan[0..upto-1]; entered and left just after a falling edge.
  task automatic run_plan(input string tag, input logic [5:0] op, input logic [5:0] funct, input int upto);
    ctl_t a;
    n_req = 0; n_rw = 0; n_pcen = 0; n_err = 0;
    bus.op = op; bus.funct = funct;
    for (int i = 0; i < upto && i < plan.size(); i++) begin
      bus.mem_ready = plan[i].rdy;
      bus.zero      = plan[i].z;
      #1;
      a = act();
      checks++;
      if (a !== plan[i].e) begin
        failures++;
        $display("FAIL %s cycle %0d: outputs got %h want %h", tag, i, a, plan[i].e);
      end
      n_req += int'(a.mem_req); n_rw += int'(a.regwrite);
      n_pcen += int'(a.pcen);   n_err += int'(a.err);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t tbl[16];
    logic [5:0] ops[8];
    logic [5:0] functs[5];
    logic [5:0] op, funct;
    int fs, ms;
    ctl_t a;

    tbl[0]  = '{"lw_memrd_stall3", LW,  6'h00, 1'b0, 0, 3, 5, 1, 1, 0};
    tbl[1]  = '{"sw",              SW,  6'h00, 1'b0, 0, 0, 2, 0, 1, 0};
    tbl[2]  = '{"add",             RT,  6'h20, 1'b0, 0, 0, 1, 1, 1, 0};
    tbl[3]  = '{"beq_taken",       BEQ, 6'h00, 1'b1, 0, 0, 1, 0, 2, 0};
    tbl[4]  = '{"beq_not_taken",   BEQ, 6'h00, 1'b0, 0, 0, 1, 0, 1, 0};
    tbl[5]  = '{"lui",             LUI, 6'h00, 1'b0, 0, 0, 1, 1, 1, 0};
    tbl[6]  = '{"ori",             ORI, 6'h00, 1'b1, 0, 0, 1, 1, 1, 0};
    tbl[7]  = '{"addi_fetch_st1",  ADDI,6'h00, 1'b0, 1, 0, 2, 1, 1, 0};
    tbl[8]  = '{"j",               JMP, 6'h00, 1'b0, 0, 0, 1, 0, 2, 0};
    tbl[9]  = '{"illegal_op",      6'h3f, 6'h00, 1'b0, 0, 0, 1, 0, 1, 1};
    tbl[10] = '{"illegal_funct",   RT,  6'h07, 1'b0, 0, 0, 1, 0, 1, 1};
    tbl[11] = '{"sw_timeout",      SW,  6'h00, 1'b0, 0, 8, 9, 0, 1, 1};
    tbl[12] = '{"fetch_timeout",   RT,  6'h20, 1'b0, 8, 0, 8, 0, 0, 1};
    tbl[13] = '{"lw_ready_at_lim", LW,  6'h00, 1'b0, 0, 7, 9, 1, 1, 0};
    tbl[14] = '{"sub_fetch_st2",   RT,  6'h22, 1'b0, 2, 0, 3, 1, 1, 0};
    tbl[15] = '{"slt",             RT,  6'h2a, 1'b1, 0, 0, 1, 1, 1, 0};

    ops    = '{LW, SW, RT, BEQ, ADDI, ORI, LUI, JMP};
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    reset = 1'b1;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    a = act();
    checks++;
    if (a !== dflt()) begin
      failures++;
      $display("FAIL reset_state: outputs got %h want %h", a, dflt());
    end
    reset = 1'b0;

    // Directed instruction table.
    rnd_mode = 1'b0;
    foreach (tbl[i]) begin
      zfix = tbl[i].z;
      build(tbl[i].op, tbl[i].funct, tbl[i].fs, tbl[i].ms);
      run_plan(tbl[i].name, tbl[i].op, tbl[i].funct, plan.size());
      chk({tbl[i].name, "_mem_req_cycles"}, n_req, tbl[i].n_req);
      chk({tbl[i].name, "_regwrite_cycles"}, n_rw, tbl[i].n_rw);
      chk({tbl[i].name, "_pcen_cycles"}, n_pcen, tbl[i].n_pcen);
      chk({tbl[i].name, "_err_cycles"}, n_err, tbl[i].n_err);
    end

    // Reset asserted in the lw writeback cycle kills regwrite at once.
    zfix = 1'b0;
    build(LW, 6'h00, 0, 0);
    run_plan("lw_before_reset", LW, 6'h00, 4);
    bus.mem_ready = 1'b1; bus.zero = 1'b1;
    #1;
    chk("memwb_regwrite_before_reset", int'(bus.regwrite), 1);
    reset = 1'b1;
    #1;
    a = act();
    checks++;
    if (a !== dflt()) begin
      failures++;
      $display("FAIL reset_mid_memwb: outputs got %h want %h", a, dflt());
    end
    @(negedge clk);
    #1;
    reset = 1'b0;
    build(JMP, 6'h00, 0, 0);
    run_plan("j_after_reset", JMP, 6'h00, plan.size());
    chk("j_after_reset_pcen_cycles", n_pcen, 2);

    // Randomized instruction stream against the model.
    rnd_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
      funct = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : functs[$urandom_range(0, 4)];
      fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0;
      ms = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : 0;
      build(op, funct, fs, ms);
      run_plan("random", op, funct, plan.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
